reg_file_2r1w: RTL and testbench

//   MIPS general-purpose register file, 32 x 32-bit, two read ports and one write port.

---
 rtl/reg_file_2r1w_pkg.sv | 24 ++
 rtl/reg_clear_seq.sv | 48 ++++
 rtl/reg_file_2r1w.sv | 77 +++++++
 tb/tb_reg_file_2r1w.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// Package: reg_file_2r1w_pkg
// Purpose: Shared sizing constants and clear-sequencer state encodings for
//          the MIPS general-purpose register file (reg_file_2r1w) and its
//          clear sequencer (reg_clear_seq).
// Contents:
//   RF_DATA_W    register width in bits
//   RF_ADDR_W    register address width
//   RF_NUM_REGS  register count (2**RF_ADDR_W)
//   RF_REG_ZERO  address of the hard-wired $zero register
//   ST_CLEAR     sequencer state: zeroing registers, user writes blocked
//   ST_READY     sequencer state: normal operation
package reg_file_2r1w_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

    localparam logic [RF_ADDR_W-1:0] RF_REG_ZERO = '0;

    // Single-bit encodings kept identical to the legacy header values.
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

endpackage

// File: rtl/reg_clear_seq.sv
// Module: reg_clear_seq
// Purpose: Post-reset clear sequencer. After reset deasserts it walks a
//          pointer over every register address, one per clock, and then
//          reports READY.
// Ports:
//   clk       in   1       rising-edge clock
//   reset     in   1       synchronous, active-high reset
//   clr_en    out  1       write a zero to clr_addr at the coming edge
//   clr_addr  out  ADDR_W  register being cleared at the coming edge
//   busy      out  1       high while in the CLEAR state
module reg_clear_seq
    import reg_file_2r1w_pkg::*;
#(
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

    logic              r_state;
    logic [ADDR_W-1:0] r_clr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else if (r_state == ST_CLEAR) begin
            // The pointer wraps to 0 on the same edge that leaves CLEAR, so
            // it is already at 0 should another reset arrive later.
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            if (r_clr_ptr == LAST_PTR) begin
                r_state <= ST_READY;
            end
        end
    end

    assign busy     = (r_state == ST_CLEAR);
    // No clear write happens on a reset edge; the pointer is restarting.
    assign clr_en   = busy && !reset;
    assign clr_addr = r_clr_ptr;

endmodule

// File: rtl/reg_file_2r1w.sv
// Module: reg_file_2r1w
// Purpose: MIPS general-purpose register file, NUM_REGS x DATA_W, two
//          asynchronous read ports and one synchronous write port, with a
//          post-reset clear sequence that zeroes every register before
//          user writes are accepted.
// Ports:
//   clk             in   1       single clock, rising edge
//   reset           in   1       synchronous, active-high reset
//   reg_write_in    in   1       write enable (RegWrite)
//   write_reg_in    in   ADDR_W  destination register (write-register mux)
//   write_data_in   in   DATA_W  write-back data
//   read_reg1_in    in   ADDR_W  rs address
//   read_reg2_in    in   ADDR_W  rt address
//   read_data1_out  out  DATA_W  contents of read_reg1_in
//   read_data2_out  out  DATA_W  contents of read_reg2_in
//   init_busy_out   out  1       high while the clear sequence runs
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write_in,
    input  logic [ADDR_W-1:0] write_reg_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [ADDR_W-1:0] read_reg1_in,
    input  logic [ADDR_W-1:0] read_reg2_in,
    output logic [DATA_W-1:0] read_data1_out,
    output logic [DATA_W-1:0] read_data2_out,
    output logic              init_busy_out
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_busy;
    logic              w_user_we;

    reg_clear_seq #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr),
        .busy     (w_busy)
    );

    // User writes only in READY, never on a reset edge, never to $zero.
    assign w_user_we = !w_busy && !reset && reg_write_in &&
                       (write_reg_in != ADDR_W'(RF_REG_ZERO));

    // Storage has no reset; contents are established by the clear sequence.
    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_regs[w_clr_addr] <= '0;
        end else if (w_user_we) begin
            r_regs[write_reg_in] <= write_data_in;
        end
    end

    // Reads have no write-through bypass: a same-cycle write is seen only
    // after the edge. Gating during CLEAR also keeps uninitialised storage
    // off the outputs.
    assign read_data1_out = (w_busy || read_reg1_in == ADDR_W'(RF_REG_ZERO)) ?
                            '0 : r_regs[read_reg1_in];
    assign read_data2_out = (w_busy || read_reg2_in == ADDR_W'(RF_REG_ZERO)) ?
                            '0 : r_regs[read_reg2_in];

    assign init_busy_out = w_busy;

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

    localparam int NREG = 32;

    logic        clk;
    logic        reset;
    logic        reg_write_in;
    logic [4:0]  write_reg_in;
    logic [31:0] write_data_in;
    logic [4:0]  read_reg1_in;
    logic [4:0]  read_reg2_in;
    logic [31:0] read_data1_out;
    logic [31:0] read_data2_out;
    logic        init_busy_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register contents plus number of clear edges still owed.
    logic [31:0] m_regs [NREG];
    int          m_clr_left = NREG;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [5];

    reg_file_2r1w dut (
        .clk            (clk),
        .reset          (reset),
        .reg_write_in   (reg_write_in),
        .write_reg_in   (write_reg_in),
        .write_data_in  (write_data_in),
        .read_reg1_in   (read_reg1_in),
        .read_reg2_in   (read_reg2_in),
        .read_data1_out (read_data1_out),
        .read_data2_out (read_data2_out),
        .init_busy_out  (init_busy_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Write-register mux: RegDst=0 selects rt, RegDst=1 selects rd.
    function automatic logic [4:0] wr_mux(input logic regdst, input logic [4:0] rt,
                                          input logic [4:0] rd);
        return regdst ? rd : rt;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (m_clr_left > 0 || a == 5'd0) return 32'h0;
        return m_regs[a];
    endfunction

    // Apply one rising edge to the model using the inputs presented to the DUT.
    task automatic model_edge();
        if (reset) begin
            m_clr_left = NREG;
        end else if (m_clr_left > 0) begin
            m_regs[NREG - m_clr_left] = 32'h0;
            m_clr_left--;
        end else if (reg_write_in && write_reg_in != 5'd0) begin
            m_regs[write_reg_in] = write_data_in;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_model(input string name);
        chk({name, "_busy"}, {31'd0, init_busy_out}, {31'd0, m_clr_left > 0});
        chk({name, "_rd1"}, read_data1_out, model_read(read_reg1_in));
        chk({name, "_rd2"}, read_data2_out, model_read(read_reg2_in));
    endtask

    // Count edges until busy falls, bounded so a stuck sequencer cannot hang.
    task automatic count_busy(output int n);
        n = 0;
        while (init_busy_out === 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] ra1, input logic [4:0] ra2);
        reg_write_in  = we;
        write_reg_in  = wa;
        write_data_in = wd;
        read_reg1_in  = ra1;
        read_reg2_in  = ra2;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < NREG; i++) begin
            read_reg1_in = 5'(i);
            read_reg2_in = 5'(NREG - 1 - i);
            #1;
            chk({name, "_p1"}, read_data1_out, 32'h0);
            chk({name, "_p2"}, read_data2_out, 32'h0);
        end
    endtask

    initial begin
        int n;
        logic [4:0] w;

        for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;

        vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8, 5'd31, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b1, 5'd31, 32'h12345678, 5'd8, 5'd31, 32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0};
        vecs[3] = '{1'b1, 5'd5,  32'h00000011, 5'd5, 5'd0,  32'h00000011, 32'h0};
        vecs[4] = '{1'b0, 5'd8,  32'h0BADF00D, 5'd8, 5'd5,  32'hDEADBEEF, 32'h00000011};

        // Reset clear: two reset cycles, then exactly 32 busy edges.
        reset = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        step();
        step();
        chk("reset_busy", {31'd0, init_busy_out}, 32'd1);
        chk("reset_rd1", read_data1_out, 32'h0);
        reset = 1'b0;
        count_busy(n);
        chk("clear_edges", 32'(n), 32'd32);
        sweep_zero("post_clear");

        // Write/read, $zero and plain reads from the vector table.
        for (int i = 0; i < 5; i++) begin
            set_in(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
            step();
            chk($sformatf("vec%0d_busy", i), {31'd0, init_busy_out}, 32'd0);
            chk($sformatf("vec%0d_rd1", i), read_data1_out, vecs[i].e1);
            chk($sformatf("vec%0d_rd2", i), read_data2_out, vecs[i].e2);
        end

        // Same-cycle read/write of r5: old value before the edge, new after.
        set_in(1'b1, 5'd5, 32'h00000022, 5'd5, 5'd5);
        #1;
        chk("rw_before", read_data1_out, 32'h00000011);
        step();
        chk("rw_after1", read_data1_out, 32'h00000022);
        chk("rw_after2", read_data2_out, 32'h00000022);

        // Writes held through CLEAR are ignored until the first READY edge.
        reset = 1'b1;
        set_in(1'b1, 5'd3, 32'h000000AA, 5'd3, 5'd8);
        step();
        reset = 1'b0;
        count_busy(n);
        chk("wclr_edges", 32'(n), 32'd32);
        chk("wclr_r3_ready", read_data1_out, 32'h0);
        chk("wclr_r8_cleared", read_data2_out, 32'h0);
        step();
        chk("wclr_r3_written", read_data1_out, 32'h000000AA);

        // Write-register mux: rt/rd select decides the destination.
        set_in(1'b1, wr_mux(1'b0, 5'd10, 5'd20), 32'hCAFE0010, 5'd10, 5'd20);
        step();
        chk("mux_rt_r10", read_data1_out, 32'hCAFE0010);
        chk("mux_rt_r20", read_data2_out, 32'h0);
        set_in(1'b1, wr_mux(1'b1, 5'd10, 5'd20), 32'hCAFE0020, 5'd10, 5'd20);
        step();
        chk("mux_rd_r10", read_data1_out, 32'hCAFE0010);
        chk("mux_rd_r20", read_data2_out, 32'hCAFE0020);

        // Reset mid-clear at clr_ptr=17: full sequence restarts.
        reset = 1'b1;
        set_in(1'b0, 5'd0, 32'h0, 5'd3, 5'd10);
        step();
        reset = 1'b0;
        for (int i = 0; i < 17; i++) step();
        chk("mid_busy", {31'd0, init_busy_out}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        count_busy(n);
        chk("mid_edges", 32'(n), 32'd32);
        sweep_zero("mid_clear");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            w = 5'($urandom);
            set_in(1'($urandom), w, $urandom,
                   ($urandom_range(0, 3) == 0) ? w : 5'($urandom), 5'($urandom));
            #1;
            chk_model("rand_pre");
            step();
            chk_model("rand_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
